// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the main-memory port arbiter.
// Holds the FSM state type and the owner codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_FIN   = 2'd2
    } arb_state_t;

    localparam logic ARB_OWN_I = 1'b0;
    localparam logic ARB_OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache miss
// handlers, one whole-line burst per grant, never preempted.
//
// Ports:
//   CPU_CLK, CPU_RST_N        clock, synchronous active-low reset
//   I_Req/I_Addr              I-side line read request
//   I_Gnt/I_RValid/I_RData    I-side grant and read beats
//   I_Done                    I-side burst-complete pulse
//   D_Req/D_We/D_Addr/D_WData D-side read or write request
//   D_Gnt/D_WReady/D_RValid   D-side grant, write accept, read beats
//   D_RData/D_Done            D-side read data, burst-complete pulse
//   Beat                      word index within the current burst
//   M_Req/M_We/M_Addr/M_WData memory beat request
//   M_Ack/M_RData             memory beat completion and read data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                          CPU_CLK,
    input  logic                          CPU_RST_N,
    input  logic                          I_Req,
    input  logic [ADDR_W-1:0]             I_Addr,
    output logic                          I_Gnt,
    output logic                          I_RValid,
    output logic [DATA_W-1:0]             I_RData,
    output logic                          I_Done,
    input  logic                          D_Req,
    input  logic                          D_We,
    input  logic [ADDR_W-1:0]             D_Addr,
    input  logic [DATA_W-1:0]             D_WData,
    output logic                          D_Gnt,
    output logic                          D_WReady,
    output logic                          D_RValid,
    output logic [DATA_W-1:0]             D_RData,
    output logic                          D_Done,
    output logic [$clog2(LINE_WORDS)-1:0] Beat,
    output logic                          M_Req,
    output logic                          M_We,
    output logic [ADDR_W-1:0]             M_Addr,
    output logic [DATA_W-1:0]             M_WData,
    input  logic                          M_Ack,
    input  logic [DATA_W-1:0]             M_RData
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = BEAT_W + 2;

    localparam logic [BEAT_W-1:0] LAST_BEAT =
        BEAT_W'(LINE_WORDS - 1);

    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~ADDR_W'((1 << OFF_W) - 1);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic                owner_q;
    logic                starve_q;
    logic                we_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   addr_q;

    logic                any_req;
    logic                grant;
    logic                pick_i;
    logic                beat_ack;
    logic                last_beat;
    logic [BEAT_W-1:0]   beat_inc;
    logic [ADDR_W-1:0]   req_base;
    logic [ADDR_W-1:0]   next_off;

    // D normally wins a tie; a passed-over I request wins the next one.
    always_comb begin
        any_req   = I_Req || D_Req;
        grant     = (state_q == ARB_IDLE) && any_req;
        pick_i    = I_Req && (!D_Req || starve_q);
        req_base  = (pick_i ? I_Addr : D_Addr) & LINE_MASK;
        beat_ack  = (state_q == ARB_BURST) && M_Ack;
        last_beat = (beat_q == LAST_BEAT);
        beat_inc  = beat_q + BEAT_W'(1);
        next_off  = ADDR_W'({beat_inc, 2'b00});
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) state_d = ARB_BURST;
            end
            ARB_BURST: begin
                if (beat_ack && last_beat) state_d = ARB_FIN;
            end
            ARB_FIN: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            state_q  <= ARB_IDLE;
            owner_q  <= ARB_OWN_D;
            starve_q <= 1'b0;
            we_q     <= 1'b0;
            beat_q   <= '0;
            base_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= pick_i ? ARB_OWN_I : ARB_OWN_D;
                we_q    <= !pick_i && D_We;
                beat_q  <= '0;
                base_q  <= req_base;
                addr_q  <= req_base;
                if (pick_i) begin
                    starve_q <= 1'b0;
                end else if (I_Req) begin
                    starve_q <= 1'b1;
                end
            end else if (beat_ack && !last_beat) begin
                // Final ack leaves Beat and M_Addr on the last word.
                beat_q <= beat_inc;
                addr_q <= base_q + next_off;
            end
        end
    end

    always_comb begin
        I_Gnt    = (state_q != ARB_IDLE) && (owner_q == ARB_OWN_I);
        D_Gnt    = (state_q != ARB_IDLE) && (owner_q == ARB_OWN_D);
        I_RValid = beat_ack && (owner_q == ARB_OWN_I);
        D_RValid = beat_ack && (owner_q == ARB_OWN_D) && !we_q;
        D_WReady = beat_ack && (owner_q == ARB_OWN_D) && we_q;
        I_Done   = (state_q == ARB_FIN) && (owner_q == ARB_OWN_I);
        D_Done   = (state_q == ARB_FIN) && (owner_q == ARB_OWN_D);
        I_RData  = M_RData;
        D_RData  = M_RData;
        Beat     = beat_q;
        M_Req    = (state_q == ARB_BURST);
        M_We     = (state_q == ARB_BURST) && we_q;
        M_Addr   = addr_q;
        M_WData  = D_WData;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and memory,
// expected beats queued at grant time and popped by a monitor.
module tb_mem_port_arbiter;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid, i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_wready, d_rvalid, d_done;
    logic [31:0] d_rdata;
    logic [2:0]  beat;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)
    ) dut (
        .CPU_CLK(clk), .CPU_RST_N(rst_n),
        .I_Req(i_req), .I_Addr(i_addr), .I_Gnt(i_gnt),
        .I_RValid(i_rvalid), .I_RData(i_rdata), .I_Done(i_done),
        .D_Req(d_req), .D_We(d_we), .D_Addr(d_addr),
        .D_WData(d_wdata), .D_Gnt(d_gnt), .D_WReady(d_wready),
        .D_RValid(d_rvalid), .D_RData(d_rdata), .D_Done(d_done),
        .Beat(beat), .M_Req(m_req), .M_We(m_we), .M_Addr(m_addr),
        .M_WData(m_wdata), .M_Ack(m_ack), .M_RData(m_rdata)
    );

    // kind: 0 I read, 1 D read, 2 D write, 3 I done, 4 D done
    typedef struct {
        int          kind;
        int          beat;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    bit   armed = 0;

    // stimulus knobs
    bit          i_en = 0, d_en = 0, stray = 0;
    bit          i_fix = 0, d_fix = 0;
    logic [31:0] i_fix_addr = '0, d_fix_addr = '0;
    int          d_we_mode = 0;
    int          raise_pct = 100;
    int          ack_every = 1;
    int          ack_pct = 50;
    int          cyc = 0;

    // requester state
    bit          i_done_seen = 0, d_done_seen = 0;
    int          i_cool = 0, d_cool = 0;
    int          d_wbeat = 0;
    logic [31:0] d_base = '0;

    // reference model: port free / bursting (counting acks) / cooldown
    int          ph = 0;
    int          macks = 0;
    int          mbeat = 0;
    bit          mown_d = 1;
    bit          mwe = 0;
    bit          skipped = 0;
    logic [31:0] mbase = '0;

    function automatic logic [31:0] rdfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] wdfn(input logic [31:0] b,
                                         input int k);
        return rdfn(b) ^ {24'h5A5A5A, 8'(k)};
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % (LW * 4));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, expv, cyc);
        end
    endtask

    // monitor: every output event consumes one scoreboard entry
    always @(negedge clk) begin
        int   nev;
        int   kind;
        exp_t e;
        if (armed) begin
            nev = int'(i_rvalid) + int'(d_rvalid) + int'(d_wready)
                + int'(i_done) + int'(d_done);
            kind = i_rvalid ? 0 : d_rvalid ? 1 : d_wready ? 2 :
                   i_done ? 3 : 4;
            if (nev > 1) begin
                chk("one_event", nev, 1);
            end else if (nev == 1) begin
                if (expq.size() == 0) begin
                    chk("spurious_event", kind, 99);
                end else begin
                    e = expq.pop_front();
                    chk("ev_kind", kind, e.kind);
                    chk("ev_beat", beat, e.beat);
                    if (e.kind < 3) chk("ev_addr", m_addr, e.addr);
                    if (e.kind == 0) chk("i_rdata", i_rdata, e.data);
                    if (e.kind == 1) chk("d_rdata", d_rdata, e.data);
                    if (e.kind == 2) begin
                        chk("m_wdata", m_wdata, e.data);
                        chk("m_we_wr", m_we, 1);
                    end
                end
            end
        end
    end

    task automatic model_grant();
        bit          win_i;
        logic [31:0] a;
        exp_t        e;
        win_i = i_req && (!d_req || skipped);
        if (win_i) skipped = 0;
        else if (i_req) skipped = 1;
        a      = win_i ? i_addr : d_addr;
        mbase  = line_of(a);
        mown_d = !win_i;
        mwe    = !win_i && d_we;
        for (int k = 0; k < LW; k++) begin
            e.kind = win_i ? 0 : (mwe ? 2 : 1);
            e.beat = k;
            e.addr = mbase + 32'(4 * k);
            e.data = (e.kind == 2) ? wdfn(mbase, k) : rdfn(e.addr);
            expq.push_back(e);
        end
        e.kind = win_i ? 3 : 4;
        e.beat = LW - 1;
        e.addr = '0;
        e.data = '0;
        expq.push_back(e);
        ph    = 1;
        macks = 0;
        mbeat = 0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            ph = 0; macks = 0; mbeat = 0; mown_d = 1;
            mwe = 0; skipped = 0; mbase = '0;
            expq.delete();
        end else if (ph == 0) begin
            if (i_req || d_req) model_grant();
        end else if (ph == 1) begin
            if (m_ack) begin
                macks++;
                mbeat = (macks < LW) ? macks : LW - 1;
                if (macks == LW) ph = 2;
            end
        end else begin
            ph = 0;
        end
    endtask

    task automatic cycle(input bit do_rst);
        @(posedge clk);
        #1;
        rst_n = !do_rst;
        if (i_done_seen) begin
            i_req = 0; i_cool = 1; i_done_seen = 0;
        end else if (i_cool > 0) begin
            i_cool--;
        end else if (!i_req && i_en &&
                     $urandom_range(99) < raise_pct) begin
            i_req  = 1;
            i_addr = i_fix ? i_fix_addr : $urandom;
        end
        if (d_done_seen) begin
            d_req = 0; d_cool = 1; d_done_seen = 0;
        end else if (d_cool > 0) begin
            d_cool--;
        end else if (!d_req && d_en &&
                     $urandom_range(99) < raise_pct) begin
            d_req   = 1;
            d_addr  = d_fix ? d_fix_addr : $urandom;
            d_we    = (d_we_mode == 2) ? 1'($urandom_range(1))
                                       : 1'(d_we_mode);
            d_base  = line_of(d_addr);
            d_wbeat = 0;
        end
        d_wdata = wdfn(d_base, d_wbeat);
        if (ack_every > 0) m_ack = (cyc % ack_every) == 0;
        else m_ack = $urandom_range(99) < ack_pct;
        if (!stray && !m_req) m_ack = 0;
        if (do_rst) m_ack = 0;
        m_rdata = rdfn(m_addr);
        cyc++;
        @(negedge clk);
        if (armed) begin
            chk("ctl", {m_req, i_gnt, d_gnt, m_we},
                {ph == 1, ph != 0 && !mown_d, ph != 0 && mown_d,
                 ph == 1 && mwe});
            chk("beat", beat, mbeat);
            if (ph == 1) chk("maddr", m_addr, mbase + 32'(4 * mbeat));
        end
        if (i_done) i_done_seen = 1;
        if (d_done) d_done_seen = 1;
        if (d_wready) d_wbeat++;
        model_step();
        if (do_rst) begin
            i_done_seen = 0; d_done_seen = 0; d_wbeat = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_en = 0;
        d_en = 0;
        while ((i_req || d_req || ph != 0) && n < 400) begin
            cycle(0);
            n++;
        end
        chk("drain_in_time", n < 400, 1);
        repeat (2) cycle(0);
    endtask

    initial begin
        bit found;
        cycle(1);
        armed = 1;
        cycle(1);
        chk("rst_maddr", m_addr, 0);
        chk("rst_events", {i_rvalid, d_rvalid, d_wready, i_done, d_done},
            0);

        // line read on the I side, ack every cycle
        ack_every = 1; raise_pct = 100;
        i_fix = 1; i_fix_addr = 32'h0000_1234;
        i_en = 1;
        repeat (12) cycle(0);
        drain();

        // simultaneous reads: D first, then the starved I side
        i_fix = 0; d_we_mode = 0;
        i_en = 1; d_en = 1;
        repeat (45) cycle(0);
        drain();

        // D write burst, slow memory
        d_fix = 1; d_fix_addr = 32'h0000_2000; d_we_mode = 1;
        ack_every = 3; d_en = 1;
        repeat (30) cycle(0);
        drain();
        d_fix = 0;

        // reset in the middle of an I burst, then restart
        ack_every = 1; i_fix = 1; i_en = 1;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            cycle(0);
            if (ph == 1 && macks == 3 && !mown_d) found = 1;
        end
        chk("rst_reached", found, 1);
        cycle(1);
        i_en = 0;
        repeat (14) cycle(0);
        drain();
        i_fix = 0;

        // stray acks on an idle port, then a D read
        stray = 1; ack_every = 0; ack_pct = 70;
        repeat (12) cycle(0);
        stray = 0; ack_every = 1; d_we_mode = 0; d_en = 1;
        repeat (4) cycle(0);
        drain();

        // back-to-back D reads with I held
        d_en = 1; i_en = 1; d_we_mode = 0;
        repeat (40) cycle(0);
        drain();

        // random traffic
        stray = 1; ack_every = 0; ack_pct = 60;
        raise_pct = 30; d_we_mode = 2;
        i_en = 1; d_en = 1;
        repeat (1500) cycle(0);
        stray = 0;
        drain();
        chk("scoreboard_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backing main-memory port between the instruction-cache miss handler (IF side) and the data-cache miss/writeback handler (MEM side) of the RISC-V pipeline CPU.
- Each grant is a whole-line burst of LINE_WORDS words. A grant is never preempted once it has started.
- Read bursts serve both sides. Write bursts are data side only.
- Sits between the two cache controllers and the memory model/BRAM wrapper.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- LINE_WORDS, 8, words per burst (power of 2, ≥2)

Ports:
- CPU_CLK  in  1  clock
- CPU_RST_N  in  1  reset: synchronous, active-low
- I_Req  in  1  instruction-side line read request; held until I_Done
- I_Addr  in  ADDR_W  instruction line address; stable while I_Req
- I_Gnt  out  1  instruction side owns the port
- I_RValid  out  1  I_RData holds word Beat of the line
- I_RData  out  DATA_W  read data
- I_Done  out  1  one-cycle pulse, burst complete
- D_Req  in  1  data-side request; held until D_Done
- D_We  in  1  1 = write burst, 0 = read burst; stable while D_Req
- D_Addr  in  ADDR_W  data line address
- D_WData  in  DATA_W  write word for current Beat
- D_Gnt  out  1  data side owns the port
- D_WReady  out  1  D_WData for current Beat consumed this cycle
- D_RValid  out  1  D_RData holds word Beat
- D_RData  out  DATA_W  read data
- D_Done  out  1  one-cycle pulse, burst complete
- Beat  out  clog2(LINE_WORDS)  index of current word in burst
- M_Req  out  1  memory beat request
- M_We  out  1  memory write enable
- M_Addr  out  ADDR_W  word address of current beat
- M_WData  out  DATA_W  write data
- M_Ack  in  1  beat complete; M_RData valid when !M_We
- M_RData  in  DATA_W  memory read data

Behaviour:
- FSM states:
  - IDLE -> BURST when any request is present.
  - BURST -> FIN on the edge where M_Ack is sampled with Beat==LINE_WORDS-1.
  - FIN -> IDLE unconditionally.
- Owner register:
  - Written only in IDLE; holds I or D.
  - I_Gnt = (owner==I) in BURST/FIN. D_Gnt likewise.
- Arbitration in IDLE:
  - Only one request: that side wins.
  - Both requesting: D wins unless the starve flag is set, in which case I wins.
  - Starve flag sets when I_Req loses arbitration. It clears when I is granted.
- Base address: the requester address with its low clog2(LINE_WORDS)+2 bits forced to zero, latched on grant.
  - M_Addr = base + 4*Beat. It is registered and updates the cycle after each M_Ack.
- Memory side in BURST:
  - M_Req=1 continuously across all beats.
  - M_We = latched (owner==D && D_We). It is 0 for every I burst.
  - M_WData = D_WData, combinational pass-through.
- Beat counter:
  - Cleared on entering BURST.
  - Increments on each M_Ack.
  - The final ack does not wrap the counter; Beat holds LINE_WORDS-1 through FIN.
- Per-ack outputs (combinational):
  - I_RValid = M_Ack && BURST && owner==I.
  - D_RValid = M_Ack && BURST && owner==D && !We.
  - D_WReady = M_Ack && BURST && owner==D && We.
  - I_RData and D_RData both = M_RData.
- Done:
  - xx_Done=1 only in FIN, for the owner.
  - The requester must drop Req by the cycle after FIN; IDLE samples Req in that cycle.
- Latency:
  - Req sampled in IDLE at cycle 0. M_Req is asserted from cycle 1.
  - With ack every cycle, Done appears in cycle LINE_WORDS+1.
  - Between bursts, M_Req is 0 for exactly 2 cycles (FIN, IDLE).
- Reset values: state=IDLE, owner=D, Beat=0, starve=0, M_Req=0, M_We=0, M_Addr=0, all Gnt/Done/Valid/WReady=0.
- Reset mid-burst: return to IDLE next cycle with all outputs at reset values, and no Done pulse. The memory model must discard the abandoned beat.
- Request changes while not owner: ignored. A request dropped before grant is never served.
- M_Ack outside BURST: ignored; no state change.

Decomposition:
- Parameters.v gains:
  - state encodings ARB_IDLE=2'd0, ARB_BURST=2'd1, ARB_FIN=2'd2
  - owner codes ARB_OWN_I=1'b0, ARB_OWN_D=1'b1
- No sub-module. Beat counter and address adder stay inline; the block is under 200 lines.

Test Plan:
1. I_Req only, I_Addr=0x0000_1234, LINE_WORDS=8, M_Ack every cycle:
   - M_Addr steps 0x1220..0x123C.
   - I_RValid pulses 8 times with Beat 0..7.
   - I_Done in cycle 9.
   - M_We=0 throughout.
2. I_Req and D_Req (read) raised together, starve=0:
   - D burst first, starve set.
   - At the next IDLE, with both requesting again, I is granted and starve clears.
3. D write burst, D_Addr=0x2000, M_Ack every 3rd cycle:
   - D_WReady exactly on ack cycles.
   - M_WData equals D_WData for Beat 0..7.
   - M_Addr holds between acks.
4. CPU_RST_N=0 for one cycle at Beat=3 of an I burst:
   - Next cycle: M_Req=0, I_Gnt=0, Beat=0, no I_Done.
   - A fresh I_Req restarts at Beat 0.
5. Stray M_Ack pulses while in IDLE:
   - No Valid/WReady/Done and no Beat change.
   - A subsequent D read completes normally with 8 beats.
6. Back-to-back D read bursts with I_Req held throughout:
   - After the first D burst, I is granted before the second D burst (no starvation).
   - M_Req is low exactly 2 cycles between bursts.
